mem_read_ctrl: RTL

MEM_READ_CTRL -- requirements
Module: mem_read_ctrl

---
 rtl/mem_read_ctrl_if.sv | 42 ++++
 rtl/mem_read_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_read_ctrl_if.sv
// mem_read_ctrl_if
// Bundles the control-unit request side, the memory bus and the downstream
// data-register load port of mem_read_ctrl into one interface.
//
// Signals:
//   req, we, addr[15:0], wdata[15:0]  request from the control unit
//   mem_addr[15:0], mem_wdata[15:0]   registered address/data to memory
//   mem_rd, mem_wr                    memory strobes
//   mem_ack, mem_rdata[15:0]          memory completion and read data
//   dr_en, dr_in[15:0]                downstream data register load
//   busy, done, err                   transaction status
//
// Modports:
//   slave  - the controller itself
//   master - the surrounding environment (control unit plus memory)
interface mem_read_ctrl_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        dr_en;
  logic [15:0] dr_in;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  req, we, addr, wdata, mem_ack, mem_rdata,
    output mem_addr, mem_wdata, mem_rd, mem_wr, dr_en, dr_in, busy, done, err
  );

  modport master (
    output req, we, addr, wdata, mem_ack, mem_rdata,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, dr_en, dr_in, busy, done, err
  );
endinterface

// File: rtl/mem_read_ctrl.sv
// mem_read_ctrl
// Single-transaction memory access controller. A one-cycle req in IDLE
// latches address and write data, raises mem_rd or mem_wr until mem_ack,
// then spends one FIN cycle pulsing done (and dr_en for reads) before
// returning to IDLE. Requests arriving while busy are dropped.
//
// Ports:
//   clk    system clock, rising edge
//   rst_b  asynchronous reset, active-high despite the suffix
//   bus    mem_read_ctrl_if.slave (request, memory bus, data register, status)
//
// Parameter:
//   TIMEOUT_CYCLES  wait cycles before abort (1..255), used only with the
//                   timeout feature
//
// Build option:
//   MEM_TIMEOUT_EN  when defined, an 8-bit wait counter aborts a wait that
//                   sees no ack within TIMEOUT_CYCLES cycles and reports it
//                   through err. Undefined: waits are unbounded, err is 0.
module mem_read_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic           clk,
  input logic           rst_b,
  mem_read_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;
  localparam logic [1:0] FIN     = 2'd3;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..255");
  end

  logic [1:0]  state;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic [15:0] dr_in_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic        dr_en_q;
  logic        busy_q;
  logic        done_q;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;
  logic       timeout_hit;

  // The counter holds the number of already-elapsed ack-less wait cycles,
  // so the current cycle is the last allowed one when it equals limit-1.
  assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

  // State machine and all registered outputs. Strobes, done and dr_en are
  // set on the edge that enters the state they belong to, so every output
  // comes straight from a flop.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state       <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dr_in_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      dr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            mem_addr_q  <= bus.addr;
            mem_wdata_q <= bus.wdata;
            busy_q      <= 1'b1;
            if (bus.we) begin
              state    <= WR_WAIT;
              mem_wr_q <= 1'b1;
            end else begin
              state    <= RD_WAIT;
              mem_rd_q <= 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
          end
        end

        // Both wait states share completion logic; only a read loads the
        // downstream data register. Ack is tested first so it beats a
        // timeout landing in the same cycle.
        RD_WAIT, WR_WAIT: begin
          if (bus.mem_ack) begin
            state    <= FIN;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            done_q   <= 1'b1;
            if (state == RD_WAIT) begin
              dr_in_q <= bus.mem_rdata;
              dr_en_q <= 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_hit) begin
            state    <= FIN;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end

        // FIN never looks at req or mem_ack; err is left standing until the
        // next accepted request.
        FIN: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          dr_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.dr_en     = dr_en_q;
  assign bus.dr_in     = dr_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef MEM_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
